banked_slow_memory: RTL

Parametrised multi-port, fixed-latency line memory model used beside `CHIP` in the system testbench and in FPGA bring-up. It replaces the separate per-cache slow memories with one shared backing array served to `NUM_PORTS` cache-refill channels (port 0 = I-cache, port 1 = D-cache by convention). Arbitration is round-robin. Per-request latency is configurable. Each port keeps the existing read/write/ready handshake on 128-bit lines.

---
 rtl/mem_model_pkg.sv | 17 +
 rtl/banked_slow_memory_rr_arbiter.sv | 47 ++++
 rtl/banked_slow_memory.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/mem_model_pkg.sv
// Shared types and helpers for the banked slow memory model.
package mem_model_pkg;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } mem_state_e;

   localparam int unsigned LINE_ADDR_W = 28;
   localparam int unsigned LINE_DATA_W = 128;

   function automatic int unsigned index_w(input int unsigned depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/banked_slow_memory_rr_arbiter.sv
// Round-robin arbiter: search starts one past the last granted port.
module rr_arbiter
   import mem_model_pkg::*;
#(
   parameter int unsigned NUM_PORTS = 2,
   localparam int unsigned ID_W = index_w(NUM_PORTS)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NUM_PORTS-1:0] req,
   input  logic                 en,
   output logic [NUM_PORTS-1:0] gnt,
   output logic [ID_W-1:0]      gnt_id,
   output logic                 gnt_vld
);

   logic [ID_W-1:0] ptr;
   logic [ID_W-1:0] cand;
   int unsigned     cand_i;

   always_comb begin
      gnt     = '0;
      gnt_id  = '0;
      gnt_vld = 1'b0;
      cand_i  = 0;
      cand    = '0;
      for (int unsigned i = 1; i <= NUM_PORTS; i++) begin
         cand_i = 32'(ptr) + i;
         if (cand_i >= NUM_PORTS) cand_i = cand_i - NUM_PORTS;
         cand = ID_W'(cand_i);
         if (en && !gnt_vld && req[cand]) begin
            gnt[cand] = 1'b1;
            gnt_id    = cand;
            gnt_vld   = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr <= ID_W'(NUM_PORTS - 1);
      end else if (gnt_vld) begin
         ptr <= gnt_id;
      end
   end

endmodule

// File: rtl/banked_slow_memory.sv
// Shared fixed-latency line memory serving NUM_PORTS refill channels.
// Define MEM_STATS_EN to add per-port read/write/wait statistics outputs.
module banked_slow_memory
   import mem_model_pkg::*;
#(
   parameter int unsigned NUM_PORTS = 2,
   parameter int unsigned ADDR_W    = LINE_ADDR_W,
   parameter int unsigned LINE_W    = LINE_DATA_W,
   parameter int unsigned DEPTH     = 256,
   parameter int unsigned LATENCY   = 4
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [NUM_PORTS-1:0]        mem_read,
   input  logic [NUM_PORTS-1:0]        mem_write,
   input  logic [NUM_PORTS*ADDR_W-1:0] mem_addr,
   input  logic [NUM_PORTS*LINE_W-1:0] mem_wdata,
   output logic [NUM_PORTS*LINE_W-1:0] mem_rdata,
   output logic [NUM_PORTS-1:0]        mem_ready
`ifdef MEM_STATS_EN
   ,
   output logic [NUM_PORTS*16-1:0]     stat_reads,
   output logic [NUM_PORTS*16-1:0]     stat_writes,
   output logic [NUM_PORTS*16-1:0]     stat_wait
`endif
);

   localparam int unsigned IDX_W = index_w(DEPTH);
   localparam int unsigned ID_W  = index_w(NUM_PORTS);
   localparam int unsigned CNT_W = 4;

   logic [LINE_W-1:0] mem [DEPTH];

   logic [NUM_PORTS-1:0][ADDR_W-1:0] addr_v;
   logic [NUM_PORTS-1:0][LINE_W-1:0] wdata_v;
   logic [NUM_PORTS-1:0][LINE_W-1:0] rdata_q;

   mem_state_e           state, state_d;
   logic [CNT_W-1:0]     cnt, cnt_d;
   logic [ID_W-1:0]      gid_q;
   logic                 wr_q;
   logic [IDX_W-1:0]     idx_q;
   logic [LINE_W-1:0]    wdata_q;
   logic [NUM_PORTS-1:0] ready_q;

   logic [NUM_PORTS-1:0] req, arb_req, arb_gnt, sel_mask, done_mask;
   logic [ID_W-1:0]      arb_id;
   logic                 arb_vld, arb_en, load, complete;
   logic                 lint_unused;

   assign addr_v      = mem_addr;
   assign wdata_v     = mem_wdata;
   assign req         = mem_read | mem_write;
   assign mem_rdata   = rdata_q;
   assign mem_ready   = ready_q;
   assign lint_unused = ^{mem_addr, arb_gnt};

   always_comb begin
      sel_mask        = '0;
      sel_mask[gid_q] = 1'b1;
      done_mask       = (state == DONE) ? sel_mask : '0;
   end

   // Arbitrating during DONE (with the finishing port masked) gives one access
   // every LATENCY+1 cycles while still never re-granting the port being answered.
   assign arb_en  = (state == IDLE) || (state == DONE);
   assign arb_req = req & ~done_mask;

   rr_arbiter #(
      .NUM_PORTS(NUM_PORTS)
   ) u_arb (
      .clk    (clk),
      .rst_n  (rst_n),
      .req    (arb_req),
      .en     (arb_en),
      .gnt    (arb_gnt),
      .gnt_id (arb_id),
      .gnt_vld(arb_vld)
   );

   always_comb begin
      state_d  = state;
      cnt_d    = cnt;
      load     = 1'b0;
      complete = 1'b0;
      case (state)
         IDLE: begin
            if (arb_vld) begin
               state_d = BUSY;
               cnt_d   = CNT_W'(LATENCY - 1);
               load    = 1'b1;
            end
         end
         BUSY: begin
            if (cnt == '0) begin
               state_d  = DONE;
               complete = 1'b1;
            end else begin
               cnt_d = cnt - 1'b1;
            end
         end
         DONE: begin
            if (arb_vld) begin
               state_d = BUSY;
               cnt_d   = CNT_W'(LATENCY - 1);
               load    = 1'b1;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         cnt     <= '0;
         gid_q   <= '0;
         wr_q    <= 1'b0;
         idx_q   <= '0;
         wdata_q <= '0;
         ready_q <= '0;
         rdata_q <= '0;
      end else begin
         state   <= state_d;
         cnt     <= cnt_d;
         ready_q <= '0;
         if (load) begin
            gid_q   <= arb_id;
            wr_q    <= mem_write[arb_id];
            idx_q   <= addr_v[arb_id][IDX_W-1:0];
            wdata_q <= wdata_v[arb_id];
         end
         if (complete) begin
            ready_q[gid_q] <= 1'b1;
            if (!wr_q) rdata_q[gid_q] <= mem[idx_q];
         end
      end
   end

   // Array is deliberately outside reset so preloaded contents survive rst_n.
   always_ff @(posedge clk) begin
      if (complete && wr_q) mem[idx_q] <= wdata_q;
   end

`ifdef MEM_STATS_EN
   logic [NUM_PORTS-1:0][15:0] rd_cnt, wr_cnt, wait_cnt;
   logic [NUM_PORTS-1:0]       busy_mask, waiting;

   assign busy_mask   = (state != IDLE) ? sel_mask : '0;
   assign waiting     = req & ~arb_gnt & ~busy_mask;
   assign stat_reads  = rd_cnt;
   assign stat_writes = wr_cnt;
   assign stat_wait   = wait_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_cnt   <= '0;
         wr_cnt   <= '0;
         wait_cnt <= '0;
      end else begin
         for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            if (complete && sel_mask[p] && !wr_q && (rd_cnt[p] != '1))
               rd_cnt[p] <= rd_cnt[p] + 16'd1;
            if (complete && sel_mask[p] && wr_q && (wr_cnt[p] != '1))
               wr_cnt[p] <= wr_cnt[p] + 16'd1;
            if (waiting[p] && (wait_cnt[p] != '1))
               wait_cnt[p] <= wait_cnt[p] + 16'd1;
         end
      end
   end
`endif

endmodule
